// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM (one-cycle read latency).
// Each access runs IDLE -> ACCESS -> RESP -> DONE; simultaneous requests alternate round-robin.
module mem_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          P0Req,
  input  logic [AW-1:0] P0Addr,
  input  logic [DW-1:0] P0Dout,
  input  logic          P0W,
  output logic          P0Gnt,
  output logic          P0Ack,
  output logic [DW-1:0] P0Din,
  input  logic          P1Req,
  input  logic [AW-1:0] P1Addr,
  input  logic [DW-1:0] P1Dout,
  input  logic          P1W,
  output logic          P1Gnt,
  output logic          P1Ack,
  output logic [DW-1:0] P1Din,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemDout,
  output logic          MemW,
  input  logic [DW-1:0] MemDin,
  output logic          Busy,
  output logic [1:0]    fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state;
  logic   last;
  logic   owner;
  logic   is_write;
  logic   pick1;

  // Handshake: a requester raises Req and holds it until its one-cycle Ack.
  // Addr/Dout/W are captured only at the grant edge; later changes are ignored.
  // The losing port keeps Req high and is re-evaluated at the next IDLE.
  assign pick1     = P1Req && (!P0Req || !last);
  assign Busy      = (state != IDLE);
  assign fsm_state = state;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state    <= IDLE;
      last     <= 1'b1;
      owner    <= 1'b0;
      is_write <= 1'b0;
      P0Gnt    <= 1'b0;
      P1Gnt    <= 1'b0;
      P0Ack    <= 1'b0;
      P1Ack    <= 1'b0;
      P0Din    <= '0;
      P1Din    <= '0;
      MemAddr  <= '0;
      MemDout  <= '0;
      MemW     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (P0Req || P1Req) begin
            if (pick1) begin
              owner    <= 1'b1;
              P1Gnt    <= 1'b1;
              MemAddr  <= P1Addr;
              MemDout  <= P1Dout;
              MemW     <= P1W;
              is_write <= P1W;
            end else begin
              owner    <= 1'b0;
              P0Gnt    <= 1'b1;
              MemAddr  <= P0Addr;
              MemDout  <= P0Dout;
              MemW     <= P0W;
              is_write <= P0W;
            end
            state <= ACCESS;
          end
        end
        ACCESS: begin
          MemW  <= 1'b0;
          state <= RESP;
        end
        RESP: begin
          // RAM read data is valid during this cycle; writes leave Din untouched.
          if (owner) begin
            P1Ack <= 1'b1;
            if (!is_write) P1Din <= MemDin;
          end else begin
            P0Ack <= 1'b1;
            if (!is_write) P0Din <= MemDin;
          end
          last  <= owner;
          state <= DONE;
        end
        DONE: begin
          P0Ack <= 1'b0;
          P1Ack <= 1'b0;
          P0Gnt <= 1'b0;
          P1Gnt <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed transaction table, hand-written corner sequences,
// and randomized two-requester traffic checked cycle by cycle against a transaction model.
module tb_mem_arbiter;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        P0Req, P0W, P1Req, P1W;
  logic [15:0] P0Addr, P0Dout, P1Addr, P1Dout;
  logic        P0Gnt, P0Ack, P1Gnt, P1Ack, MemW, Busy;
  logic [15:0] P0Din, P1Din, MemAddr, MemDout, MemDin;
  logic [1:0]  fsm_state;

  int checks = 0;
  int failures = 0;

  always #5 Clock = ~Clock;

  mem_arbiter #(.AW(16), .DW(16)) dut (
    .Clock(Clock), .Resetn(Resetn),
    .P0Req(P0Req), .P0Addr(P0Addr), .P0Dout(P0Dout), .P0W(P0W),
    .P0Gnt(P0Gnt), .P0Ack(P0Ack), .P0Din(P0Din),
    .P1Req(P1Req), .P1Addr(P1Addr), .P1Dout(P1Dout), .P1W(P1W),
    .P1Gnt(P1Gnt), .P1Ack(P1Ack), .P1Din(P1Din),
    .MemAddr(MemAddr), .MemDout(MemDout), .MemW(MemW), .MemDin(MemDin),
    .Busy(Busy), .fsm_state(fsm_state)
  );

  // Simple synchronous RAM, read-first, 64 words, preloaded with addr ^ 0x5A5A.
  logic [15:0] ram [64];
  bit          ram_ready;
  always @(posedge Clock) begin
    if (!ram_ready) begin
      for (int i = 0; i < 64; i++) ram[i] <= 16'(i) ^ 16'h5A5A;
      ram_ready <= 1'b1;
    end else if (MemW) begin
      ram[MemAddr[5:0]] <= MemDout;
    end
    MemDin <= ram[MemAddr[5:0]];
  end

  // ---------------- transaction-level reference model ----------------
  logic [15:0] mmem [64];
  int          n;
  int          s;
  bit          active;
  bit          co, cw, mlast;
  logic [15:0] ca, cd;
  logic [15:0] exp_addr, exp_dout, exp_din0, exp_din1;
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];

  task automatic model_reset();
    active   = 1'b0;
    mlast    = 1'b1;
    exp_addr = '0;
    exp_dout = '0;
    exp_din0 = '0;
    exp_din1 = '0;
    exp_q0.delete();
    exp_q1.delete();
  endtask

  // Called right after each rising edge, with the inputs that edge saw.
  task automatic model_edge();
    int d;
    n++;
    if (!Resetn) begin
      model_reset();
      return;
    end
    if (!active) begin
      if (P0Req || P1Req) begin
        if (P0Req && P1Req) co = !mlast;
        else                co = P1Req;
        cw       = co ? P1W : P0W;
        ca       = co ? P1Addr : P0Addr;
        cd       = co ? P1Dout : P0Dout;
        active   = 1'b1;
        s        = n;
        exp_addr = ca;
        exp_dout = cd;
      end
    end else begin
      d = n - s;
      if (d == 1) begin
        if (cw) mmem[ca[5:0]] = cd;
        else if (co) exp_q1.push_back(mmem[ca[5:0]]);
        else exp_q0.push_back(mmem[ca[5:0]]);
      end
      if (d == 2) begin
        mlast = co;
        if (!cw) begin
          if (co) exp_din1 = exp_q1.pop_front();
          else    exp_din0 = exp_q0.pop_front();
        end
      end
      if (d == 3) active = 1'b0;
    end
  endtask

  function automatic logic [69:0] expected();
    int d;
    bit g0, g1, a0, a1, w;
    d  = n - s;
    g0 = active && !co;
    g1 = active && co;
    a0 = active && (d == 2) && !co;
    a1 = active && (d == 2) && co;
    w  = active && (d == 0) && cw;
    return {g0, g1, a0, a1, w, active, exp_addr, exp_dout, exp_din0, exp_din1};
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [69:0] outs();
    return {P0Gnt, P1Gnt, P0Ack, P1Ack, MemW, Busy, MemAddr, MemDout, P0Din, P1Din};
  endfunction

  task automatic step();
    @(posedge Clock);
    model_edge();
    @(negedge Clock);
    check("cycle", outs(), expected());
    check("one_gnt", 70'(P0Gnt & P1Gnt), 70'(0));
  endtask

  task automatic drive_idle();
    P0Req = 0; P0W = 0; P0Addr = '0; P0Dout = '0;
    P1Req = 0; P1W = 0; P1Addr = '0; P1Dout = '0;
  endtask

  task automatic reset_pulse();
    Resetn = 1'b0;
    model_reset();
    #1;
    check("reset_async", outs(), 70'(0));
    step();
    Resetn = 1'b1;
  endtask

  task automatic run_single(input string name, input bit port, input bit w,
                            input logic [15:0] addr, input logic [15:0] data,
                            input logic [15:0] exp_din);
    int lat = 0;
    int wcnt = 0;
    bit got = 0;
    if (port) begin P1Req = 1; P1W = w; P1Addr = addr; P1Dout = data; end
    else      begin P0Req = 1; P0W = w; P0Addr = addr; P0Dout = data; end
    while (!got && lat < 12) begin
      step();
      lat++;
      if (MemW) wcnt++;
      if (port ? P1Ack : P0Ack) begin
        got = 1;
        if (port) P1Req = 0; else P0Req = 0;
      end
    end
    check({name, "_ack_seen"}, 70'(got), 70'(1));
    check({name, "_ack_latency"}, 70'(lat), 70'(3));
    check({name, "_memw_cycles"}, 70'(wcnt), 70'(w));
    check({name, "_din"}, 70'(port ? P1Din : P0Din), 70'(exp_din));
    step();
    step();
    check({name, "_din_held"}, 70'(port ? P1Din : P0Din), 70'(exp_din));
  endtask

  typedef struct {
    bit          port;
    bit          w;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] exp_din;
  } vec_t;
  vec_t vecs[8];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit p0_prev, p1_prev;
    int order[$];
    int p1_steps[$];
    int expect_order[4];
    logic [15:0] churn_addr;

    for (int i = 0; i < 64; i++) mmem[i] = 16'(i) ^ 16'h5A5A;
    n = 0; s = 0; co = 0; cw = 0; ca = '0; cd = '0;
    drive_idle();
    model_reset();

    // Reset state
    step();
    step();
    check("reset_state", outs(), 70'(0));
    check("reset_fsm_idle", 70'(fsm_state), 70'(0));
    Resetn = 1'b1;

    // Directed single transactions
    vecs[0] = '{1'b0, 1'b1, 16'h0005, 16'hBEEF, 16'h0000};
    vecs[1] = '{1'b0, 1'b0, 16'h0005, 16'h0000, 16'hBEEF};
    vecs[2] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'h5A4A};
    vecs[3] = '{1'b1, 1'b1, 16'h0010, 16'h1234, 16'h5A4A};
    vecs[4] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'h1234};
    vecs[5] = '{1'b1, 1'b0, 16'h0005, 16'h0000, 16'hBEEF};
    vecs[6] = '{1'b0, 1'b1, 16'h0003, 16'h0F0F, 16'h1234};
    vecs[7] = '{1'b0, 1'b0, 16'h0003, 16'h0000, 16'h0F0F};
    for (int i = 0; i < 8; i++)
      run_single($sformatf("vec%0d", i), vecs[i].port, vecs[i].w,
                 vecs[i].addr, vecs[i].data, vecs[i].exp_din);

    // Simultaneous requests after reset: expect P0, P1, P0, P1
    reset_pulse();
    P0Req = 1; P0W = 0; P0Addr = 16'h0005;
    P1Req = 1; P1W = 0; P1Addr = 16'h0003;
    p0_prev = 0; p1_prev = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (P0Gnt && !p0_prev) order.push_back(0);
      if (P1Gnt && !p1_prev) order.push_back(1);
      p0_prev = P0Gnt; p1_prev = P1Gnt;
    end
    P0Req = 0; P1Req = 0;
    step();
    step();
    expect_order = '{0, 1, 0, 1};
    check("tie_grant_count", 70'(order.size()), 70'(4));
    for (int i = 0; i < 4; i++)
      if (i < order.size())
        check($sformatf("tie_order%0d", i), 70'(order[i]), 70'(expect_order[i]));

    // P1 alone, continuous: one grant every 4 cycles, P0 never granted
    P1Req = 1; P1W = 0;
    p1_prev = 0;
    for (int k = 1; k <= 12; k++) begin
      P1Addr = 16'($urandom_range(0, 15));
      step();
      check("p1_alone_p0gnt", 70'(P0Gnt), 70'(0));
      if (P1Gnt && !p1_prev) p1_steps.push_back(k);
      p1_prev = P1Gnt;
    end
    P1Req = 0;
    step();
    step();
    check("p1_alone_count", 70'(p1_steps.size()), 70'(3));
    for (int i = 1; i < p1_steps.size(); i++)
      check("p1_alone_spacing", 70'(p1_steps[i] - p1_steps[i-1]), 70'(4));

    // Input churn during a P0 read of 0x0010
    P0Req = 1; P0W = 0; P0Addr = 16'h0010;
    step();
    check("churn_grant", 70'(P0Gnt), 70'(1));
    for (int k = 0; k < 2; k++) begin
      churn_addr = 16'h0020;
      P0Addr = churn_addr;
      P0W = 1;
      P0Dout = 16'($urandom);
      step();
      check("churn_memaddr", 70'(MemAddr), 70'(16'h0010));
    end
    check("churn_ack", 70'(P0Ack), 70'(1));
    check("churn_din", 70'(P0Din), 70'(16'h1234));
    P0Req = 0; P0W = 0;
    step();
    step();

    // Reset during RESP of a P1 read; pending P0 must win afterwards
    P1Req = 1; P1W = 0; P1Addr = 16'h0005;
    step();
    step();
    P0Req = 1; P0W = 0; P0Addr = 16'h0003;
    #2;
    Resetn = 1'b0;
    model_reset();
    #1;
    check("reset_mid_resp", outs(), 70'(0));
    step();
    check("reset_no_p1ack", 70'(P1Ack), 70'(0));
    Resetn = 1'b1;
    step();
    check("post_reset_p0gnt", 70'(P0Gnt), 70'(1));
    check("post_reset_p1gnt", 70'(P1Gnt), 70'(0));
    for (int k = 0; k < 7; k++) begin
      if (P0Ack) P0Req = 0;
      if (P1Ack) P1Req = 0;
      step();
    end
    P0Req = 0; P1Req = 0;
    step();
    check("post_reset_p0din", 70'(P0Din), 70'(16'h0F0F));
    check("post_reset_p1din", 70'(P1Din), 70'(16'hBEEF));

    // Randomized two-requester traffic with input churn while pending
    for (int k = 0; k < 800; k++) begin
      if (!P0Req && $urandom_range(0, 2) == 0) P0Req = 1;
      if (!P1Req && $urandom_range(0, 2) == 0) P1Req = 1;
      P0Addr = 16'($urandom_range(0, 15));
      P1Addr = 16'($urandom_range(0, 15));
      P0Dout = 16'($urandom);
      P1Dout = 16'($urandom);
      P0W    = 1'($urandom_range(0, 1));
      P1W    = 1'($urandom_range(0, 1));
      step();
      if (P0Ack) P0Req = 1'($urandom_range(0, 1));
      if (P1Ack) P1Req = 1'($urandom_range(0, 1));
    end
    P0Req = 0; P1Req = 0;
    for (int k = 0; k < 5; k++) step();
    check("final_idle", 70'(Busy), 70'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing one synchronous single-port RAM (registered address/data/write inputs, one-cycle read latency) between two requesters. Port 0 serves the processor's memory interface; port 1 serves a program loader or DMA engine. The arbiter sequences each access through a fixed four-state FSM, breaks contention round-robin, and returns read data with a one-cycle acknowledge pulse.

## Interface
- AW, 16, address width
- DW, 16, data width

- Clock  in  1  system clock, all state changes on rising edge
- Resetn  in  1  asynchronous, active-low reset
- P0Req  in  1  port 0 request (level, held until P0Ack)
- P0Addr  in  AW  port 0 address
- P0Dout  in  DW  port 0 write data
- P0W  in  1  port 0 write enable (1 = write, 0 = read)
- P0Gnt  out  1  port 0 owns the RAM
- P0Ack  out  1  port 0 transaction complete, one-cycle pulse
- P0Din  out  DW  port 0 read data, held until next port 0 read completes
- P1Req, P1Addr, P1Dout, P1W, P1Gnt, P1Ack, P1Din  same as port 0, for port 1
- MemAddr  out  AW  RAM address
- MemDout  out  DW  RAM write data
- MemW  out  1  RAM write enable
- MemDin  in  DW  RAM read data, valid one cycle after address is clocked in
- Busy  out  1  FSM not in IDLE

## Operation
- States: IDLE, ACCESS, RESP, DONE. Sequence IDLE -> ACCESS -> RESP -> DONE -> IDLE, with no skips or stalls.
- IDLE: if any Req is high, choose owner `o`, set PoGnt=1, register MemAddr<=PoAddr, MemDout<=PoDout, MemW<=PoW, then go to ACCESS. With no request, stay in IDLE.
- Choice of owner:
  - Only one Req high: that port wins.
  - Both high: the port not equal to Last wins (round-robin).
  - Last resets to 1, so port 0 wins the first tie.
- ACCESS: RAM samples MemAddr/MemDout/MemW on the closing edge. On that edge MemW<=0, then go to RESP.
- RESP: MemDin valid. On the closing edge:
  - For a read, PoDin<=MemDin.
  - PoAck<=1, Last<=o, then go to DONE.
- DONE: PoAck=1 for exactly this cycle. On the closing edge PoAck<=0 and PoGnt<=0, then go to IDLE.
- Writes leave PoDin unchanged; the Ack pulse still occurs.
- Address, data and W are captured only at the grant. Changes on any input during ACCESS/RESP/DONE are ignored.
- The non-owner's Req is held pending and is evaluated at the next IDLE.
- A requester wanting one transaction deasserts Req on the edge ending its Ack cycle. Keeping Req high requests a back-to-back transaction, subject to round-robin.
- MemAddr/MemDout hold their last value outside transactions.
- Busy = (state != IDLE), decoded from the state register.

## Timing
- Reset (async assert): state=IDLE, Last=1. Every output is 0: P0Gnt, P1Gnt, P0Ack, P1Ack, P0Din, P1Din, MemAddr, MemDout, MemW, Busy.
- Reset mid-transaction aborts immediately: MemW drops asynchronously and no Ack is issued. A write whose ACCESS edge already occurred has completed in RAM.
- Release of Resetn is synchronous in effect: the first possible grant is on the first rising edge with Resetn high.
- Latency: Req seen high in IDLE at edge E0 gives Gnt in cycle E0..E1, MemW in the same cycle (writes only), and Ack in the cycle after edge E2.
- A single transaction takes 4 cycles including IDLE. Peak throughput is one transaction per 4 cycles.
- Gnt is never high for both ports simultaneously. At most one Ack is high in any cycle.
- Busy is high for exactly 3 cycles per transaction.

## Test plan
- Reset, then P0 single write, then single read:
  - Stimulus: P0 write Addr=0x0005, Dout=0xBEEF, W=1; then read Addr=0x0005.
  - Response: MemW high for exactly 1 cycle. P0Ack pulses 3 cycles after each request is sampled. P0Din=0xBEEF, held after Ack.
- Simultaneous requests after reset:
  - Stimulus: P0Req and P1Req both rise in the same cycle; both held for back-to-back traffic.
  - Response: grant order P0, P1, P0, P1. No cycle with P0Gnt & P1Gnt.
- P1 alone, repeated:
  - Stimulus: P1 requests continuously; P0 idle.
  - Response: P1 is granted every transaction, one every 4 cycles. P0Gnt stays 0.
- Input churn during ACCESS:
  - Stimulus: P0 requests a read at Addr=0x0010; P0Addr changes to 0x0020 during ACCESS.
  - Response: MemAddr stays 0x0010. P0Din returns RAM[0x0010].
- Resetn asserted during RESP of a P1 read:
  - Response: all outputs go to 0 immediately and no P1Ack occurs.
  - After release, a pending P0Req is granted before P1 (Last=1).
